// File: rtl/beam_sweep_controller.sv
// Beam sweep sequencer: steps the beamformer through NUM_ANGLES banks and streams each beam's header and samples out over a byte interface.
// Optional build macro SWEEP_TIMEOUT_EN enables a RUN-state watchdog that abandons a stalled beam.
module beam_sweep_controller #(
    parameter int NUM_ANGLES       = 8,
    parameter int SAMPLES_PER_BEAM = 540,
    parameter int TIMEOUT_CYCLES   = 1048576
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  locked,
    input  logic                  sweep_go,
    output logic [((NUM_ANGLES > 1) ? $clog2(NUM_ANGLES) : 1)-1:0] angle_sel,
    output logic                  bf_rst,
    output logic                  bf_start,
    input  logic                  sum_valid,
    input  logic [39:0]           summed_value,
    output logic                  sum_hold,
    output logic [7:0]            tx_data,
    output logic                  tx_valid,
    input  logic                  tx_ready,
    output logic                  busy,
    output logic                  sweep_done,
    output logic                  overflow_err,
    output logic                  timeout_err
);
    localparam int AW = (NUM_ANGLES > 1) ? $clog2(NUM_ANGLES) : 1;
    localparam int CW = $clog2(SAMPLES_PER_BEAM + 1);

    typedef enum logic [2:0] {IDLE, RESET_BF, START, RUN, NEXT, DONE} state_t;

    state_t        state;
    logic [CW-1:0] sample_cnt;
    logic [39:0]   hold_reg;
    logic          hold_full;
    logic [2:0]    byte_idx;   // sample bytes already presented
    logic [1:0]    hdr_left;   // header bytes still to present
    logic          last_byte;  // presented byte is the 5th of the held sample
    logic [7:0]    hold_byte;
    logic          fire;
    logic          capture;
    logic          ser_empty;

`ifdef SWEEP_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] to_cnt;
`else
    assign timeout_err = 1'b0;
`endif

    assign fire      = tx_valid & tx_ready;
    assign capture   = (state == RUN) & sum_valid & ~hold_full;
    assign ser_empty = ~tx_valid & ~hold_full & (hdr_left == 2'd0);
    assign sum_hold  = hold_full;
    assign busy      = (state != IDLE);

    always_comb begin
        hold_byte = hold_reg[7:0];
        case (byte_idx)
            3'd0:    hold_byte = hold_reg[39:32];
            3'd1:    hold_byte = hold_reg[31:24];
            3'd2:    hold_byte = hold_reg[23:16];
            3'd3:    hold_byte = hold_reg[15:8];
            default: hold_byte = hold_reg[7:0];
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            angle_sel    <= '0;
            bf_rst       <= 1'b0;
            bf_start     <= 1'b0;
            sweep_done   <= 1'b0;
            overflow_err <= 1'b0;
            tx_data      <= '0;
            tx_valid     <= 1'b0;
            sample_cnt   <= '0;
            hold_reg     <= '0;
            hold_full    <= 1'b0;
            byte_idx     <= '0;
            hdr_left     <= '0;
            last_byte    <= 1'b0;
`ifdef SWEEP_TIMEOUT_EN
            to_cnt       <= '0;
            timeout_err  <= 1'b0;
`endif
        end else begin
            bf_rst     <= 1'b0;
            bf_start   <= 1'b0;
            sweep_done <= 1'b0;

            if (fire && last_byte) begin
                hold_full <= 1'b0;
                byte_idx  <= '0;
            end
            // Load a new byte whenever the output slot is empty or being accepted; header bytes win.
            if (!tx_valid || fire) begin
                if (hdr_left != 2'd0) begin
                    tx_valid  <= 1'b1;
                    tx_data   <= (hdr_left == 2'd2) ? 8'hA5 : 8'(angle_sel);
                    hdr_left  <= hdr_left - 2'd1;
                    last_byte <= 1'b0;
                end else if (hold_full && byte_idx != 3'd5) begin
                    tx_valid  <= 1'b1;
                    tx_data   <= hold_byte;
                    byte_idx  <= byte_idx + 3'd1;
                    last_byte <= (byte_idx == 3'd4);
                end else begin
                    tx_valid  <= 1'b0;
                    last_byte <= 1'b0;
                end
            end

            if (sum_valid && hold_full)
                overflow_err <= 1'b1;
            if (capture) begin
                hold_reg   <= summed_value;
                hold_full  <= 1'b1;
                byte_idx   <= '0;
                sample_cnt <= sample_cnt + CW'(1);
            end

            case (state)
                IDLE: begin
                    angle_sel <= '0;
                    if (locked && sweep_go)
                        state <= RESET_BF;
                end
                RESET_BF: begin
                    bf_rst <= 1'b1;
                    state  <= START;
                end
                START: begin
                    bf_start   <= 1'b1;
                    sample_cnt <= '0;
                    hdr_left   <= 2'd2;
`ifdef SWEEP_TIMEOUT_EN
                    to_cnt     <= '0;
`endif
                    state      <= RUN;
                end
                RUN: begin
                    if (sample_cnt == CW'(SAMPLES_PER_BEAM) && ser_empty)
                        state <= NEXT;
`ifdef SWEEP_TIMEOUT_EN
                    if (capture) begin
                        to_cnt <= '0;
                    end else if (to_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
                        timeout_err <= 1'b1;
                        hold_full   <= 1'b0;
                        byte_idx    <= '0;
                        hdr_left    <= '0;
                        tx_valid    <= 1'b0;
                        last_byte   <= 1'b0;
                        state       <= NEXT;
                    end else begin
                        to_cnt <= to_cnt + TW'(1);
                    end
`endif
                end
                NEXT: begin
                    if (angle_sel == AW'(NUM_ANGLES - 1)) begin
                        state <= DONE;
                    end else begin
                        angle_sel <= angle_sel + AW'(1);
                        state     <= RESET_BF;
                    end
                end
                DONE: begin
                    sweep_done <= 1'b1;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_beam_sweep_controller.sv
// Randomized scoreboard bench for beam_sweep_controller; expected byte stream is built from the sweep rules.
module tb_beam_sweep_controller;
    localparam int NA = 3;
    localparam int NS = 3;
    localparam int TO = 64;
    localparam int AW = 2;

    localparam int W_START = 0;
    localparam int W_DONE  = 1;
    localparam int W_FREE  = 2;
    localparam int W_TXV   = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          locked = 1'b0;
    logic          sweep_go = 1'b0;
    logic [AW-1:0] angle_sel;
    logic          bf_rst, bf_start;
    logic          sum_valid = 1'b0;
    logic [39:0]   summed_value = '0;
    logic          sum_hold;
    logic [7:0]    tx_data;
    logic          tx_valid;
    logic          tx_ready = 1'b0;
    logic          busy, sweep_done, overflow_err, timeout_err;

    int total = 0;
    int bad = 0;
    int n_start = 0, n_rst = 0, n_done = 0;
    int ready_mode = 0;
    logic [7:0] exp_q[$];
    logic       pend = 1'b0;
    logic [7:0] pend_data;
    logic [7:0] e;

    beam_sweep_controller #(
        .NUM_ANGLES(NA),
        .SAMPLES_PER_BEAM(NS),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .rst(rst), .locked(locked), .sweep_go(sweep_go),
        .angle_sel(angle_sel), .bf_rst(bf_rst), .bf_start(bf_start),
        .sum_valid(sum_valid), .summed_value(summed_value), .sum_hold(sum_hold),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .busy(busy), .sweep_done(sweep_done),
        .overflow_err(overflow_err), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    function automatic bit sig_now(input int w);
        case (w)
            W_START: return bf_start;
            W_DONE:  return sweep_done;
            W_FREE:  return !sum_hold;
            default: return tx_valid;
        endcase
    endfunction

    task automatic wait_for(input int w, input int limit);
        int n = 0;
        while (!sig_now(w) && n < limit) begin
            @(posedge clk); #1;
            n++;
        end
        if (!sig_now(w)) check($sformatf("wait_timeout_%0d", w), 64'(sig_now(w)), 64'd1);
    endtask

    task automatic reset_vector_check(input string name);
        check(name, 64'({angle_sel, bf_rst, bf_start, sum_hold, tx_data, tx_valid,
                         busy, sweep_done, overflow_err, timeout_err}), 64'd0);
    endtask

    task automatic send(input logic [39:0] v, input bit ov);
        wait_for(W_FREE, 300);
        sum_valid    = 1'b1;
        summed_value = v;
        for (int k = 0; k < 5; k++) exp_q.push_back(8'(v >> (8 * (4 - k))));
        @(posedge clk); #1;
        if (ov) begin
            summed_value = ~v;
            @(posedge clk); #1;
        end
        sum_valid = 1'b0;
    endtask

    // mode: 0 random samples, 1 fixed first sample, 2 overflow on first sample
    task automatic run_beam(input int b, input int mode);
        logic [39:0] v;
        wait_for(W_START, 100);
        exp_q.push_back(8'hA5);
        exp_q.push_back(8'(b));
        for (int s = 0; s < NS; s++) begin
            for (int g = int'($urandom_range(0, 6)); g > 0; g--) begin
                @(posedge clk); #1;
            end
            v = {8'($urandom), 32'($urandom)};
            if (mode == 1 && s == 0) v = 40'h80_1234_5678;
            send(v, mode == 2 && s == 0);
        end
    endtask

    task automatic run_sweep(input int mode, input bit drop_early, input bit drop_at_end);
        for (int b = 0; b < NA; b++) begin
            run_beam(b, (b == 0) ? mode : 0);
            if (drop_early && b == 0) sweep_go = 1'b0;
        end
        wait_for(W_DONE, 300);
        if (drop_at_end) sweep_go = 1'b0;
    endtask

    initial forever begin
        @(posedge clk); #2;
        case (ready_mode)
            0:       tx_ready = ($urandom_range(0, 9) < 7);
            1:       tx_ready = 1'b1;
            2:       tx_ready = ~tx_ready;
            default: tx_ready = 1'b0;
        endcase
    end

    // Monitor: pulse counting, byte ordering against the scoreboard, and hold-until-accepted.
    always @(negedge clk) begin
        if (rst) begin
            pend = 1'b0;
        end else begin
            n_start += int'(bf_start);
            n_rst   += int'(bf_rst);
            n_done  += int'(sweep_done);
            if (tx_valid) begin
                if (pend) check("tx_stable", 64'(tx_data), 64'(pend_data));
                if (tx_ready) begin
                    if (exp_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL tx_unexpected: got %0h want none", tx_data);
                    end else begin
                        e = exp_q.pop_front();
                        check("tx_byte", 64'(tx_data), 64'(e));
                    end
                    pend = 1'b0;
                end else begin
                    pend      = 1'b1;
                    pend_data = tx_data;
                end
            end else if (pend) begin
                total++;
                bad++;
                $display("FAIL tx_dropped: got tx_valid=0 want 1 data %0h", pend_data);
                pend = 1'b0;
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int starts_before;
        repeat (3) @(posedge clk);
        #1;
        reset_vector_check("reset_outputs");
        rst = 1'b0;

        // PLL lock gates sweep start
        sweep_go = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        check("unlocked_busy", 64'(busy), 64'd0);
        check("unlocked_bf_rst", 64'(n_rst), 64'd0);
        locked = 1'b1;
        @(posedge clk); #1;
        check("bf_rst_early", 64'(bf_rst), 64'd0);
        @(posedge clk); #1;
        check("bf_rst_latency", 64'(bf_rst), 64'd1);

        // two back-to-back sweeps with sweep_go held
        run_sweep(0, 1'b0, 1'b0);
        run_sweep(0, 1'b0, 1'b1);
        repeat (10) @(posedge clk);
        #1;
        check("b2b_done_count", 64'(n_done), 64'd2);
        check("b2b_start_count", 64'(n_start), 64'(2 * NA));
        check("b2b_rst_count", 64'(n_rst), 64'(2 * NA));
        check("b2b_queue_empty", 64'(exp_q.size()), 64'd0);
        check("b2b_idle", 64'(busy), 64'd0);

        // toggling tx_ready, fixed sample, sweep_go dropped mid-sweep
        ready_mode = 2;
        sweep_go   = 1'b1;
        run_sweep(1, 1'b1, 1'b0);
        ready_mode = 0;
        repeat (10) @(posedge clk);
        #1;
        check("drop_go_done_count", 64'(n_done), 64'd3);
        check("drop_go_no_restart", 64'(n_start), 64'(3 * NA));
        check("no_overflow_yet", 64'(overflow_err), 64'd0);
        check("drop_go_queue_empty", 64'(exp_q.size()), 64'd0);

        // overflow: second back-to-back sum_valid is dropped
        sweep_go = 1'b1;
        run_sweep(2, 1'b0, 1'b1);
        repeat (10) @(posedge clk);
        #1;
        check("overflow_flag", 64'(overflow_err), 64'd1);
        check("overflow_done_count", 64'(n_done), 64'd4);
        check("overflow_queue_empty", 64'(exp_q.size()), 64'd0);

        // reset while a byte is stalled
        ready_mode = 3;
        @(posedge clk); #1;
        sweep_go = 1'b1;
        wait_for(W_TXV, 50);
        check("stalled_header", 64'(tx_data), 64'hA5);
        rst      = 1'b1;
        sweep_go = 1'b0;
        @(posedge clk); #1;
        reset_vector_check("midbyte_reset_outputs");
        rst = 1'b0;
        exp_q.delete();

        // RUN with no samples: watchdog build abandons beams, default build waits
        ready_mode    = 1;
        starts_before = n_start;
        sweep_go      = 1'b1;
`ifdef SWEEP_TIMEOUT_EN
        for (int b = 0; b < NA; b++) begin
            wait_for(W_START, 3 * TO);
            exp_q.push_back(8'hA5);
            exp_q.push_back(8'(b));
            sweep_go = 1'b0;
        end
        wait_for(W_DONE, 3 * TO);
        repeat (5) @(posedge clk);
        #1;
        check("timeout_flag", 64'(timeout_err), 64'd1);
        check("timeout_starts", 64'(n_start - starts_before), 64'(NA));
        check("timeout_queue_empty", 64'(exp_q.size()), 64'd0);
`else
        wait_for(W_START, 100);
        exp_q.push_back(8'hA5);
        exp_q.push_back(8'h00);
        sweep_go = 1'b0;
        repeat (4 * TO) @(posedge clk);
        #1;
        check("no_timeout_busy", 64'(busy), 64'd1);
        check("no_timeout_angle", 64'(angle_sel), 64'd0);
        check("no_timeout_starts", 64'(n_start - starts_before), 64'd1);
        check("no_timeout_flag", 64'(timeout_err), 64'd0);
        check("no_timeout_queue_empty", 64'(exp_q.size()), 64'd0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("recover_idle", 64'(busy), 64'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
